// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC and arbitrates sequential fetch, redirects, stalls and halt.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned branch targets into trap redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        if_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_t;

  state_t      state, next_state;
  logic [31:0] pend_target, pend_target_d;
  logic        pend_is_trap, pend_is_trap_d;
  logic [31:0] pc_next_int;
  logic        flush_int;
  logic        take_mis;
  logic [31:0] br_eff;
  logic        br_mis;
  logic [31:0] hold_target;
  logic        hold_trap;

`ifdef PC_MISALIGN_TRAP_EN
  assign br_mis = |br_target[1:0];
  assign br_eff = br_mis ? TRAP_VECTOR : br_target;
`else
  assign br_mis = 1'b0;
  assign br_eff = {br_target[31:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        if (trap_req || br_taken) next_state = imem_ready ? RUN : HOLD;
        else if (halt_req)        next_state = HALT;
      end
      HOLD: if (imem_ready) next_state = RUN;
      HALT: if (resume)     next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // A misaligned target promoted to TRAP_VECTOR is tracked as a trap so later branches cannot displace it.
  always_comb begin
    pc_next_int    = pc;
    flush_int      = 1'b0;
    take_mis       = 1'b0;
    pend_target_d  = pend_target;
    pend_is_trap_d = pend_is_trap;
    hold_target    = pend_target;
    hold_trap      = pend_is_trap;
    case (state)
      RUN: begin
        if (trap_req) begin
          flush_int = 1'b1;
          if (imem_ready) pc_next_int = TRAP_VECTOR;
          else begin
            pend_target_d  = TRAP_VECTOR;
            pend_is_trap_d = 1'b1;
          end
        end else if (br_taken) begin
          flush_int = 1'b1;
          take_mis  = br_mis;
          if (imem_ready) pc_next_int = br_eff;
          else begin
            pend_target_d  = br_eff;
            pend_is_trap_d = br_mis;
          end
        end else if (!halt_req && !stall && imem_ready) begin
          pc_next_int = pc + 32'd4;
        end
      end
      HOLD: begin
        if (trap_req) begin
          flush_int   = 1'b1;
          hold_target = TRAP_VECTOR;
          hold_trap   = 1'b1;
        end else if (br_taken && !pend_is_trap) begin
          flush_int   = 1'b1;
          take_mis    = br_mis;
          hold_target = br_eff;
          hold_trap   = br_mis;
        end
        if (imem_ready) begin
          pc_next_int    = hold_target;
          pend_target_d  = 32'd0;
          pend_is_trap_d = 1'b0;
        end else begin
          pend_target_d  = hold_target;
          pend_is_trap_d = hold_trap;
        end
      end
      default: ;
    endcase
  end

  assign pc_next     = rst ? RESET_VECTOR : pc_next_int;
  assign if_valid    = (state == RUN) & ~rst;
  assign flush_if_id = flush_int & ~rst;
  assign flush_id_ex = flush_int & ~rst;
  assign halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      pend_target  <= 32'd0;
      pend_is_trap <= 1'b0;
    end else begin
      pc           <= pc_next_int;
      pend_target  <= pend_target_d;
      pend_is_trap <= pend_is_trap_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'd0;
    end else begin
      misalign <= take_mis;
      if (take_mis) misalign_addr <= br_target;
    end
  end
`else
  assign misalign      = 1'b0;
  assign misalign_addr = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each step queues the post-edge PC/valid/halted expectation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, imem_ready, br_taken, trap_req, halt_req, resume;
  logic [31:0] br_target;
  logic [31:0] pc, pc_next, misalign_addr;
  logic        if_valid, flush_if_id, flush_id_ex, halted, misalign;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_next(pc_next),
    .if_valid(if_valid), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .halted(halted), .misalign(misalign), .misalign_addr(misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},     pc,              e.pc);
      chk({e.tag, ".valid"},  {31'd0, if_valid}, {31'd0, e.valid});
      chk({e.tag, ".halted"}, {31'd0, halted},   {31'd0, e.halted});
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, queue the post-edge state, then compare it.
  task automatic applyStimulus(input string tag, input logic r, input logic st, input logic rdy,
                               input logic bt, input logic [31:0] tgt, input logic tr,
                               input logic hr, input logic rs, input logic exp_flush,
                               input logic [31:0] exp_pc, input logic exp_v, input logic exp_h);
    exp_t e;
    rst = r; stall = st; imem_ready = rdy; br_taken = bt; br_target = tgt;
    trap_req = tr; halt_req = hr; resume = rs;
    #1;
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, exp_flush});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, exp_flush});
    chk({tag, ".pc_next"},     pc_next,              exp_pc);
    e.tag = tag; e.pc = exp_pc; e.valid = exp_v; e.halted = exp_h;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  logic [31:0] mis_pc, mis_pc_seq, mis_addr_exp;
  logic        mis_pulse_exp;

  initial begin
`ifdef PC_MISALIGN_TRAP_EN
    mis_pc = 32'h100; mis_pc_seq = 32'h104; mis_pulse_exp = 1'b1; mis_addr_exp = 32'h42;
`else
    mis_pc = 32'h40;  mis_pc_seq = 32'h44;  mis_pulse_exp = 1'b0; mis_addr_exp = 32'h0;
`endif
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    chk("reset.pc",       pc,                   32'h0);
    chk("reset.pc_next",  pc_next,              32'h0);
    chk("reset.valid",    {31'd0, if_valid},    32'h0);
    chk("reset.flush",    {31'd0, flush_if_id}, 32'h0);
    chk("reset.halted",   {31'd0, halted},      32'h0);
    chk("reset.misalign", {31'd0, misalign},    32'h0);
    chk("reset.mis_addr", misalign_addr,        32'h0);

    //             tag        rst st  rdy bt  target          tr  hr  rs  fl  exp_pc          v   h
    applyStimulus("boot",     0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h0,          1,  0);
    applyStimulus("seq4",     0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h4,          1,  0);
    applyStimulus("seq8",     0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h8,          1,  0);
    applyStimulus("seqC",     0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'hC,          1,  0);
    applyStimulus("seq10",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h10,         1,  0);
    applyStimulus("br40",     0,  0,  1,  1,  32'h40,         0,  0,  0,  1,  32'h40,         1,  0);
    applyStimulus("seq44",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h44,         1,  0);
    applyStimulus("stall",    0,  1,  1,  0,  32'h0,          0,  0,  0,  0,  32'h44,         1,  0);
    applyStimulus("trap_br",  0,  0,  1,  1,  32'h200,        1,  0,  0,  1,  32'h100,        1,  0);
    applyStimulus("seq104",   0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h104,        1,  0);
    applyStimulus("hold_in",  0,  0,  0,  1,  32'h80,         0,  0,  0,  1,  32'h104,        0,  0);
    applyStimulus("hold_1",   0,  0,  0,  0,  32'h0,          0,  0,  0,  0,  32'h104,        0,  0);
    applyStimulus("hold_2",   0,  0,  0,  0,  32'h0,          0,  0,  0,  0,  32'h104,        0,  0);
    applyStimulus("hold_out", 0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h80,         1,  0);
    applyStimulus("seq84",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h84,         1,  0);
    applyStimulus("br1C",     0,  0,  1,  1,  32'h1C,         0,  0,  0,  1,  32'h1C,         1,  0);
    applyStimulus("seq20",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h20,         1,  0);
    applyStimulus("halt",     0,  0,  1,  0,  32'h0,          0,  1,  0,  0,  32'h20,         0,  1);
    applyStimulus("halt_br",  0,  0,  1,  1,  32'h300,        0,  0,  0,  0,  32'h20,         0,  1);
    applyStimulus("halt_tr",  0,  1,  1,  0,  32'h0,          1,  0,  0,  0,  32'h20,         0,  1);
    applyStimulus("resume",   0,  0,  1,  0,  32'h0,          0,  0,  1,  0,  32'h20,         1,  0);
    applyStimulus("seq24",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h24,         1,  0);
    applyStimulus("br42",     0,  0,  1,  1,  32'h42,         0,  0,  0,  1,  mis_pc,         1,  0);
    chk("br42.misalign", {31'd0, misalign}, {31'd0, mis_pulse_exp});
    chk("br42.mis_addr", misalign_addr,     mis_addr_exp);
    applyStimulus("after42",  0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  mis_pc_seq,     1,  0);
    chk("after42.misalign", {31'd0, misalign}, 32'h0);
    chk("after42.mis_addr", misalign_addr,     mis_addr_exp);
    applyStimulus("brTop",    0,  0,  1,  1,  32'hFFFF_FFFC,  0,  0,  0,  1,  32'hFFFF_FFFC,  1,  0);
    applyStimulus("wrap",     0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h0,          1,  0);
    applyStimulus("hold_rst", 0,  0,  0,  1,  32'h60,         0,  0,  0,  1,  32'h0,          0,  0);
    applyStimulus("rst_mid",  1,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h0,          0,  0);
    applyStimulus("reboot",   0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h0,          1,  0);
    applyStimulus("seq4b",    0,  0,  1,  0,  32'h0,          0,  0,  0,  0,  32'h4,          1,  0);
    applyStimulus("hold_br2", 0,  0,  0,  1,  32'h80,         0,  0,  0,  1,  32'h4,          0,  0);
    applyStimulus("hold_tr",  0,  0,  0,  0,  32'h0,          1,  0,  0,  1,  32'h4,          0,  0);
    applyStimulus("hold_brx", 0,  0,  1,  1,  32'h90,         0,  0,  0,  0,  32'h100,        1,  0);
    applyStimulus("br_halt",  0,  0,  1,  1,  32'h30,         0,  1,  0,  1,  32'h30,         1,  0);
    applyStimulus("halt2",    0,  0,  1,  0,  32'h0,          0,  1,  0,  0,  32'h30,         0,  1);
    applyStimulus("resume2",  0,  0,  1,  0,  32'h0,          0,  0,  1,  0,  32'h30,         1,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
